// File: rtl/ysyx_22050550_fetch_redirect_ctrl.sv
// ysyx_22050550_fetch_redirect_ctrl: fetch PC sequencer with redirect arbitration and stale-fetch discard
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   redir_{trap,mret,br}_valid_i/pc_i  redirect requests, priority trap > mret > br
//   imem_req_valid_o/ready_i/addr_o    single-outstanding instruction fetch request
//   imem_resp_valid_i/data_i           fetch response pulse and instruction
//   if_valid_o/if_pc_o/if_inst_o, id_ready_i  instruction handed to decode
//   flush_o                        redirect accepted this cycle
//   redir_cnt_o                    wrapping count of accepted redirects
module ysyx_22050550_fetch_redirect_ctrl #(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000),
  parameter int unsigned       CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              redir_trap_valid_i,
  input  logic [ADDR_W-1:0] redir_trap_pc_i,
  input  logic              redir_mret_valid_i,
  input  logic [ADDR_W-1:0] redir_mret_pc_i,
  input  logic              redir_br_valid_i,
  input  logic [ADDR_W-1:0] redir_br_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_resp_valid_i,
  input  logic [31:0]       imem_resp_data_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [31:0]       if_inst_o,
  input  logic              id_ready_i,
  output logic              flush_o,
  output logic [CNT_W-1:0]  redir_cnt_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, KILL, HOLD} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, sel, tgt, if_pc_q;
  logic [31:0]       if_inst_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_valid_q, if_valid_q, redir;
  assign redir = redir_trap_valid_i | redir_mret_valid_i | redir_br_valid_i;
  assign sel = redir_trap_valid_i ? redir_trap_pc_i : redir_mret_valid_i ? redir_mret_pc_i : redir_br_pc_i;
  assign tgt = {sel[ADDR_W-1:2], 2'b00};
  assign flush_o = redir & rst_ni;
  assign imem_req_valid_o = req_valid_q;
  // The request address is the fetch PC itself, so a redirect in REQ retargets the pending request.
  assign imem_req_addr_o = pc_q;
  assign if_valid_o = if_valid_q;
  assign if_pc_o = if_pc_q;
  assign if_inst_o = if_inst_q;
  assign redir_cnt_o = cnt_q;
  always_comb begin
    state_d = state_q;
    pc_d = redir ? tgt : pc_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = !imem_req_ready_i ? REQ : redir ? KILL : WAIT;
      WAIT: state_d = imem_resp_valid_i ? (redir ? REQ : HOLD) : (redir ? KILL : WAIT);
      // KILL owns exactly one response: the one belonging to the request it replaced.
      KILL: state_d = imem_resp_valid_i ? REQ : KILL;
      HOLD: begin
        state_d = (redir | id_ready_i) ? REQ : HOLD;
        pc_d = redir ? tgt : id_ready_i ? pc_q + ADDR_W'(4) : pc_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      req_valid_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q <= RESET_PC;
      if_inst_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_valid_q <= state_d == REQ;
      if_valid_q <= state_d == HOLD;
      if (state_q == WAIT && imem_resp_valid_i && !redir) begin
        if_pc_q <= pc_q;
        if_inst_q <= imem_resp_data_i;
      end
      if (redir) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ysyx_22050550_fetch_redirect_ctrl.sv
// tb_ysyx_22050550_fetch_redirect_ctrl: randomized and directed check of the fetch redirect controller against a transaction-level model
module tb_ysyx_22050550_fetch_redirect_ctrl;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        trap_v = 1'b0, mret_v = 1'b0, br_v = 1'b0;
  logic [63:0] trap_pc = '0, mret_pc = '0, br_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        if_valid, id_ready = 1'b1, flush;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] redir_cnt;
  int vecs = 0, errs = 0;
  logic [63:0] hs_log[$], acc_log[$];
  bit pend = 0;
  int dly = 0, fixed_dly = 0;

  ysyx_22050550_fetch_redirect_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .redir_trap_valid_i(trap_v), .redir_trap_pc_i(trap_pc),
    .redir_mret_valid_i(mret_v), .redir_mret_pc_i(mret_pc),
    .redir_br_valid_i(br_v), .redir_br_pc_i(br_pc),
    .imem_req_valid_o(imem_req_valid), .imem_req_ready_i(imem_req_ready), .imem_req_addr_o(imem_req_addr),
    .imem_resp_valid_i(imem_resp_valid), .imem_resp_data_i(imem_resp_data),
    .if_valid_o(if_valid), .if_pc_o(if_pc), .if_inst_o(if_inst), .id_ready_i(id_ready),
    .flush_o(flush), .redir_cnt_o(redir_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a fetch is either being requested, outstanding (possibly stale), or held for decode.
  bit m_start, m_req, m_out, m_stale, m_held;
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_inst, m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_start = 0; m_req = 0; m_out = 0; m_stale = 0; m_held = 0;
      m_pc = RST_PC; m_ipc = RST_PC; m_inst = 0; m_cnt = 0;
    end else begin
      bit red;
      logic [63:0] tg;
      red = trap_v | mret_v | br_v;
      tg = (trap_v ? trap_pc : mret_v ? mret_pc : br_pc) & ~64'd3;
      if (!m_start) begin
        m_start = 1; m_req = 1;
      end else if (m_req) begin
        if (imem_req_ready) begin m_req = 0; m_out = 1; m_stale = red; end
      end else if (m_out) begin
        if (imem_resp_valid) begin
          m_out = 0;
          if (m_stale || red) m_req = 1;
          else begin m_held = 1; m_ipc = m_pc; m_inst = imem_resp_data; end
        end else if (red) m_stale = 1;
      end else if (m_held && (red || id_ready)) begin
        m_held = 0; m_req = 1;
        if (!red) m_pc = m_pc + 64'd4;
      end
      if (red) begin m_pc = tg; m_cnt = m_cnt + 1; end
    end
  end

  always @(negedge clk) begin
    chk("req_valid", {63'd0, imem_req_valid}, {63'd0, m_req});
    chk("req_addr", imem_req_addr, m_pc);
    chk("if_valid", {63'd0, if_valid}, {63'd0, m_held});
    chk("flush", {63'd0, flush}, {63'd0, rst_n & (trap_v | mret_v | br_v)});
    chk("redir_cnt", {32'd0, redir_cnt}, {32'd0, m_cnt});
    if (m_held || !rst_n) begin
      chk("if_pc", if_pc, m_ipc);
      chk("if_inst", {32'd0, if_inst}, {32'd0, m_inst});
    end
  end

  // One clock: log handshakes/acceptances seen at the edge, then drive the memory response.
  task automatic step();
    bit hs;
    @(posedge clk);
    hs = rst_n && imem_req_valid && imem_req_ready;
    if (hs) hs_log.push_back(imem_req_addr);
    if (rst_n && if_valid && id_ready && !flush) acc_log.push_back(if_pc);
    #1;
    if (!rst_n) pend = 0;
    else if (hs) begin pend = 1; dly = fixed_dly >= 0 ? fixed_dly : $urandom_range(0, 2); end
    imem_resp_valid = pend && dly == 0;
    imem_resp_data = $urandom;
    if (pend) begin if (dly == 0) pend = 0; else dly--; end
  endtask

  task automatic wait_for(input bit acc, input int n0);
    int k = 0;
    while ((acc ? acc_log.size() : hs_log.size()) <= n0 && k < 60) begin step(); k++; end
    if (k == 60) begin
      vecs++; errs++;
      $display("FAIL timeout waiting for %s", acc ? "acceptance" : "handshake");
    end
  endtask

  task automatic do_reset();
    trap_v = 0; mret_v = 0; br_v = 0; rst_n = 0;
    step(); step();
    rst_n = 1;
  endtask

  initial begin
    int n0, a0;
    // Straight-line fetch
    fixed_dly = 0; imem_req_ready = 1; id_ready = 1;
    do_reset();
    chk("idle_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("idle_addr", imem_req_addr, RST_PC);
    n0 = hs_log.size(); a0 = acc_log.size();
    step();
    chk("first_req", {63'd0, imem_req_valid}, 64'd1);
    for (int i = 0; i < 3; i++) wait_for(1, a0 + i);
    chk("seq_hs0", hs_log[n0], 64'h8000_0000);
    chk("seq_hs1", hs_log[n0+1], 64'h8000_0004);
    chk("seq_hs2", hs_log[n0+2], 64'h8000_0008);
    chk("seq_if0", acc_log[a0], 64'h8000_0000);
    chk("seq_if2", acc_log[a0+2], 64'h8000_0008);
    chk("seq_cnt", {32'd0, redir_cnt}, 64'd0);
    // Redirect while waiting for the response
    do_reset();
    fixed_dly = 2; n0 = hs_log.size(); a0 = acc_log.size();
    wait_for(0, n0);
    br_v = 1; br_pc = 64'h8000_0100;
    #1 chk("wait_flush", {63'd0, flush}, 64'd1);
    step(); br_v = 0;
    wait_for(0, n0 + 1);
    chk("wait_redir_addr", hs_log[n0+1], 64'h8000_0100);
    chk("wait_redir_cnt", {32'd0, redir_cnt}, 64'd1);
    wait_for(1, a0);
    chk("wait_first_if", acc_log[a0], 64'h8000_0100);
    // Simultaneous redirects while a request is stalled
    fixed_dly = 0; imem_req_ready = 0;
    step(); step();
    n0 = hs_log.size(); a0 = redir_cnt;
    trap_v = 1; trap_pc = 64'h8000_0200; mret_v = 1; mret_pc = 64'h8000_0300; br_v = 1; br_pc = 64'h8000_0400;
    step(); trap_v = 0; mret_v = 0; br_v = 0; imem_req_ready = 1;
    wait_for(0, n0);
    chk("prio_addr", hs_log[n0], 64'h8000_0200);
    chk("prio_cnt", {32'd0, redir_cnt}, 64'(a0 + 1));
    // Stalled request retargeted, no response discarded
    imem_req_ready = 0;
    step(); step();
    n0 = hs_log.size(); a0 = acc_log.size();
    br_v = 1; br_pc = 64'h8000_1000;
    step(); br_v = 0; step(); imem_req_ready = 1;
    wait_for(1, a0);
    chk("stall_hs", hs_log[n0], 64'h8000_1000);
    chk("stall_if", acc_log[a0], 64'h8000_1000);
    // Held instruction, then mret redirect with misaligned target
    do_reset();
    id_ready = 0;
    for (int k = 0; k < 20 && !if_valid; k++) step();
    chk("hold_valid", {63'd0, if_valid}, 64'd1);
    for (int k = 0; k < 5; k++) step();
    chk("hold_pc", if_pc, 64'h8000_0000);
    n0 = hs_log.size();
    mret_v = 1; mret_pc = 64'h8000_0013;
    step(); mret_v = 0;
    chk("hold_drop", {63'd0, if_valid}, 64'd0);
    wait_for(0, n0);
    chk("hold_redir_addr", hs_log[n0], 64'h8000_0010);
    id_ready = 1;
    // Asynchronous reset while discarding a stale fetch
    fixed_dly = 2;
    n0 = hs_log.size();
    wait_for(0, n0);
    br_v = 1; br_pc = 64'h8000_0500;
    step(); br_v = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_addr", imem_req_addr, RST_PC);
    chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
    chk("rst_cnt", {32'd0, redir_cnt}, 64'd0);
    chk("rst_flush", {63'd0, flush}, 64'd0);
    br_v = 0;
    step(); rst_n = 1;
    n0 = hs_log.size();
    wait_for(0, n0);
    chk("rst_first_addr", hs_log[n0], 64'h8000_0000);
    // PC increment wraps at the top of the address space
    fixed_dly = 0; imem_req_ready = 0;
    step(); step();
    br_v = 1; br_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); br_v = 0; imem_req_ready = 1;
    n0 = hs_log.size();
    wait_for(0, n0);
    wait_for(0, n0 + 1);
    chk("wrap_top", hs_log[n0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_zero", hs_log[n0+1], 64'h0);
    // Randomized traffic
    fixed_dly = -1;
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom % 16;
      rst_n = !rst_n ? 1'b1 : ($urandom % 600 != 0);
      trap_v = r == 0 || r == 3;
      mret_v = r == 1 || r == 3;
      br_v = r == 2 || r == 3 || r == 4;
      trap_pc = {32'd0, 32'h8000_0000 | ($urandom % 4096)};
      mret_pc = {$urandom, $urandom};
      br_pc = ($urandom % 8 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {32'd0, 32'h8000_0000 | ($urandom % 4096)};
      imem_req_ready = $urandom % 4 != 0;
      id_ready = $urandom % 3 != 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
